t_pulse_debouncer: RTL and testbench
====================================

# t_pulse_debouncer

Upstream conditioning stage for `t_flip_flop`. It takes a raw, bouncing, asynchronous pushbutton level and synchronizes and debounces it. It then emits exactly one single-cycle `t` pulse per accepted press, so the downstream flip-flop's `q` toggles once per physical press. It also exports the debounced level and a wrapping press counter for observation.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required to accept a level change. Legal range is ≥ 2.
- `COUNT_W`, default 8: width of `press_count`.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `clear`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `btn`, input, 1: raw pushbutton level. Asynchronous to `clk` and may bounce.
- `t`, output, 1: registered one-cycle pulse. Drives `t_flip_flop.t`.
- `pressed`, output, 1: registered debounced button level.
- `press_count`, output, COUNT_W: number of accepted presses, modulo 2^COUNT_W.

## Operation
- **Synchronizer.** Two-flop chain `btn` → `s1` → `s2`. Only `s2` (called `btn_s`) is used by the FSM.
- **Counter.** Debounce counter `cnt` with width `$clog2(DEBOUNCE_CYCLES)+1`.
- **FSM states:** IDLE, ARM, HELD, DISARM.
  - **IDLE** (`pressed`=0): `btn_s`=1 → ARM, `cnt`=1. Otherwise stay.
  - **ARM:**
    - `btn_s`=0 → IDLE and `cnt`=0. This is a glitch rejection: no pulse, count unchanged.
    - `btn_s`=1 and `cnt`=DEBOUNCE_CYCLES-1 → HELD, with `t`←1, `pressed`←1, `press_count`←`press_count`+1.
    - Otherwise `cnt`++.
  - **HELD** (`pressed`=1): `btn_s`=0 → DISARM, `cnt`=1. Otherwise stay.
  - **DISARM:**
    - `btn_s`=1 → HELD and `cnt`=0. This is release bounce: no pulse, count unchanged.
    - `btn_s`=0 and `cnt`=DEBOUNCE_CYCLES-1 → IDLE, with `pressed`←0.
    - Otherwise `cnt`++.
- **`t` default.** `t` is 0 on every cycle except the one following the ARM→HELD transition. It is never high two cycles in a row.
- **Releases.** Releases never generate `t`. Only presses toggle the downstream flip-flop.
- **`press_count` wrap.** Wraps from 2^COUNT_W-1 to 0 with no flag.
- **Clear.** `clear`=1 has priority over all other behaviour. It forces:
  - `s1`=`s2`=0
  - state IDLE, `cnt`=0
  - `t`=0, `pressed`=0, `press_count`=0
- **Clear mid-operation.** A clear during ARM, HELD or DISARM discards the operation in progress. No pulse is emitted for it.
- **Button held through clear.** If `btn` is held high across the release of `clear`, the press is re-qualified from IDLE. It then produces one `t` pulse after the normal latency.

## Timing
- **Reset values.** `t`=0, `pressed`=0, `press_count`=0, all visible on the edge where `clear` is sampled high.
- **Synchronizer latency.** 2 edges. If edge k is the first to sample `btn`=1, then `btn_s`=1 after edge k+1.
- **Press latency.** Given `btn` held stable high from edge k:
  - ARM is entered at edge k+2.
  - HELD is entered and `t`=1 at edge k+DEBOUNCE_CYCLES+1.
  - `t` returns to 0 at edge k+DEBOUNCE_CYCLES+2.
  - For DEBOUNCE_CYCLES=4: `t` is high between edges k+5 and k+6.
- **Press acceptance.** Requires DEBOUNCE_CYCLES consecutive samples of `btn_s`=1.
- **Release acceptance.** `pressed` falls DEBOUNCE_CYCLES+1 edges after the first sampled low, given `btn` stays low.
- **Glitch rejection.** A high pulse on `btn` shorter than DEBOUNCE_CYCLES clock periods never produces `t`.
- **Downstream effect.** `t_flip_flop` sees `t` for one edge, so `q` toggles exactly once per accepted press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, COUNT_W=8, 10 ns clock.

1. **Reset:** `clear`=1 for 2 edges with `btn`=0 → `t`=0, `pressed`=0, `press_count`=0. These stay unchanged for 10 further cycles.
2. **Clean press:** `btn` 0→1, first sampled at edge k, held 12 cycles.
   - `t`=1 only between edges k+5 and k+6.
   - `pressed`=1 from edge k+5.
   - `press_count`=1.
   - With `t_flip_flop` attached, `q` goes 0→1 once.
3. **Glitch:** `btn` high for 2 cycles, then low for 10 → no `t` pulse, `pressed`=0, `press_count`=0.
4. **Release bounce:** from HELD, apply `btn` low 2 cycles, high 3, then low 8.
   - No `t` pulse.
   - `pressed` falls 5 edges after the final low is first sampled.
   - `press_count` unchanged.
5. **Wrap:** 256 clean presses → 256 single-cycle `t` pulses. `press_count` reads 255 after press 255 and 0 after press 256.
6. **Clear mid-ARM / held through clear:**
   - Assert `clear` for 1 cycle at edge k+3 of a press → no pulse from that press, state IDLE.
   - Keep `btn` high after clear drops → exactly one `t` pulse 5 edges after the first post-clear sample, `press_count`=1.

Source files
------------

// File: rtl/t_pulse_debouncer.sv
// t_pulse_debouncer: synchronizes and debounces a raw button, emitting one t pulse per accepted press.
module t_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               btn,
  output logic               t,
  output logic               pressed,
  output logic [COUNT_W-1:0] press_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_e;
  state_e             state_q, state_d;
  logic               s1_q, s2_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               t_q, t_d, pressed_q, pressed_d;
  logic [COUNT_W-1:0] count_q, count_d;
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_q       <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      s1_q      <= btn;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end
  // cnt counts consecutive synchronized samples disagreeing with the debounced level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = 1'b0;
    pressed_d = pressed_q;
    count_d   = count_q;
    case (state_q)
      IDLE: if (s2_q) begin
        state_d = ARM;
        cnt_d   = CW'(1);
      end
      ARM: if (!s2_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d   = HELD;
        cnt_d     = '0;
        t_d       = 1'b1;
        pressed_d = 1'b1;
        count_d   = count_q + COUNT_W'(1);
      end else cnt_d = cnt_q + CW'(1);
      HELD: if (!s2_q) begin
        state_d = DISARM;
        cnt_d   = CW'(1);
      end
      default: if (s2_q) begin
        state_d = HELD;
        cnt_d   = '0;
      end else if (cnt_q == LAST) begin
        state_d   = IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end else cnt_d = cnt_q + CW'(1);
    endcase
  end
  assign t           = t_q;
  assign pressed     = pressed_q;
  assign press_count = count_q;
endmodule

// File: tb/tb_t_pulse_debouncer.sv
// tb_t_pulse_debouncer: scoreboard bench comparing the debouncer to a run-length reference model.
module tb_t_pulse_debouncer;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       btn = 1'b0;
  logic       t, pressed;
  logic [7:0] press_count;
  typedef struct packed {logic t; logic p; logic [7:0] c;} exp_t;
  exp_t sb[$];
  bit   m_s1, m_s2, m_lvl, m_t;
  int   m_run, m_cnt;
  int   checks = 0, errors = 0;
  int   pulses;
  t_pulse_debouncer #(.DEBOUNCE_CYCLES(D), .COUNT_W(8)) dut (
    .clk(clk), .clear(clear), .btn(btn), .t(t), .pressed(pressed), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: the debounced level flips once D consecutive synchronized samples disagree with it
  task automatic step(input logic b, input logic c);
    exp_t e;
    btn = b;
    clear = c;
    @(posedge clk);
    if (c) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_t = 0; m_cnt = 0;
    end else begin
      m_t = 0;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = !m_lvl;
          m_run = 0;
          if (m_lvl) begin
            m_t = 1;
            m_cnt = (m_cnt + 1) % 256;
          end
        end
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = b;
    end
    e.t = m_t;
    e.p = m_lvl;
    e.c = 8'(m_cnt);
    sb.push_back(e);
    #1;
    if (t) pulses++;
  endtask
  task automatic steps(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_t", t, e.t);
      chk("sb_pressed", pressed, e.p);
      chk("sb_press_count", press_count, e.c);
    end
  end
  initial begin
    pulses = 0;
    step(0, 1);
    step(0, 1);
    chk("reset_t", t, 0);
    chk("reset_pressed", pressed, 0);
    chk("reset_count", press_count, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      chk("idle_hold", {t, pressed, press_count}, 0);
    end
    steps(1, 5);
    chk("clean_t_early", t, 0);
    step(1, 0);
    chk("clean_t", t, 1);
    chk("clean_pressed", pressed, 1);
    chk("clean_count", press_count, 1);
    step(1, 0);
    chk("clean_t_drop", t, 0);
    steps(1, 5);
    steps(0, 10);
    chk("release_pressed", pressed, 0);
    steps(1, 2);
    steps(0, 10);
    chk("glitch_pressed", pressed, 0);
    chk("glitch_count", press_count, 1);
    steps(1, 7);
    chk("held_pressed", pressed, 1);
    pulses = 0;
    steps(0, 2);
    steps(1, 3);
    steps(0, 5);
    chk("bounce_still_pressed", pressed, 1);
    step(0, 0);
    chk("bounce_release", pressed, 0);
    steps(0, 2);
    chk("bounce_no_pulse", pulses, 0);
    chk("bounce_count", press_count, 2);
    step(0, 1);
    pulses = 0;
    for (int p = 1; p <= 256; p++) begin
      steps(1, 7);
      steps(0, 7);
      if (p == 255) chk("wrap_255", press_count, 255);
    end
    chk("wrap_0", press_count, 0);
    chk("wrap_pulses", pulses, 256);
    step(0, 1);
    steps(1, 3);
    step(1, 1);
    chk("midarm_pressed", pressed, 0);
    chk("midarm_count", press_count, 0);
    pulses = 0;
    steps(1, 5);
    chk("requal_t_early", pulses, 0);
    step(1, 0);
    chk("requal_t", t, 1);
    steps(1, 5);
    chk("requal_pulses", pulses, 1);
    chk("requal_count", press_count, 1);
    steps(0, 8);
    for (int s = 0; s < 400; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 79) == 0));
    end
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
